// File: rtl/spi_reg_pkg.sv
// spi_reg_pkg: shared types and constants for the SPI register bank.
// Holds FSM states, requester ids, the default error word and the lock bit index.
package spi_reg_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_e;

  typedef enum logic {
    SRC_SPI = 1'b0,
    SRC_LOC = 1'b1
  } src_e;

  localparam logic [15:0] ERR_WORD_DEF = 16'hDEAD;
  localparam int          LOCK_BIT     = 0;

endpackage

// File: rtl/spi_reg_arb.sv
// spi_reg_arb: 2-way round-robin arbiter (SPI slot vs local bus), last-grant flop.
// Ports: clk, rst, req_spi, req_loc, take (commit grant) -> any, win_loc.
module spi_reg_arb
  import spi_reg_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic req_spi,
  input  logic req_loc,
  input  logic take,
  output logic any,
  output logic win_loc
);

  src_e last;

  // Reset treats local as last winner so SPI goes first.
  always_ff @(posedge clk) begin
    if (rst) begin
      last <= SRC_LOC;
    end else if (take && any) begin
      last <= win_loc ? SRC_LOC : SRC_SPI;
    end
  end

  always_comb begin
    any     = req_spi | req_loc;
    win_loc = req_loc & (~req_spi | (last == SRC_SPI));
  end

endmodule

// File: rtl/spi_reg_bank_ctrl.sv
// spi_reg_bank_ctrl: register bank shared by SPI commands and a local bus.
// IDLE->ACCESS->RESP sequencer; SPI read data on o_data_word_send; saturating o_err_cnt.
// Ports: i_master_clock, i_rst (sync, high), SPI cmd in, o_data_word_send,
//  local req/gnt/rvalid/rdata, o_reg0, o_err_cnt. Option: SPI_REG_WPROT_EN.
module spi_reg_bank_ctrl
  import spi_reg_pkg::*;
#(
  parameter int ADDR_LEN = 8,
  parameter int WORD_LEN = 16,
  parameter int REG_DEPTH = 32,
  parameter logic [WORD_LEN-1:0] ERR_WORD = ERR_WORD_DEF
) (
  input  logic                i_master_clock,
  input  logic                i_rst,
  input  logic                i_reg_operate,
  input  logic                i_spi_write,
  input  logic                i_spi_read,
  input  logic [ADDR_LEN-1:0] i_spi_addr,
  input  logic [WORD_LEN-1:0] i_spi_data,
  output logic [WORD_LEN-1:0] o_data_word_send,
  input  logic                i_loc_req,
  input  logic                i_loc_we,
  input  logic [ADDR_LEN-1:0] i_loc_addr,
  input  logic [WORD_LEN-1:0] i_loc_wdata,
  output logic                o_loc_gnt,
  output logic                o_loc_rvalid,
  output logic [WORD_LEN-1:0] o_loc_rdata,
  output logic [WORD_LEN-1:0] o_reg0,
  output logic [7:0]          o_err_cnt
);

  localparam int IDX_W =
    (REG_DEPTH > 1) ? $clog2(REG_DEPTH) : 1;
  localparam logic [ADDR_LEN:0] DEPTH_C =
    REG_DEPTH[ADDR_LEN:0];

  logic [WORD_LEN-1:0] bank [REG_DEPTH];

  state_e state, state_n;

  logic                slot_full;
  logic                slot_rd;
  logic [ADDR_LEN-1:0] slot_addr;
  logic [WORD_LEN-1:0] slot_data;

  src_e                acc_src;
  logic                acc_we;
  logic [ADDR_LEN-1:0] acc_addr;
  logic [WORD_LEN-1:0] acc_data;

  logic                latch_en;
  logic                slot_clr;
  logic                arb_any;
  logic                arb_win_loc;

  logic                is_access;
  logic [IDX_W-1:0]    acc_idx;
  logic                acc_mapped;
  logic [WORD_LEN-1:0] rd_word;
  logic                wr_block;
  logic                do_write;
  logic                acc_err;
  logic                cmd_valid;
  logic                drop;
  logic                load;
  logic [8:0]          err_sum;
  logic [7:0]          err_next;

  spi_reg_arb u_arb (
    .clk     (i_master_clock),
    .rst     (i_rst),
    .req_spi (slot_full),
    .req_loc (i_loc_req),
    .take    (latch_en),
    .any     (arb_any),
    .win_loc (arb_win_loc)
  );

  always_ff @(posedge i_master_clock) begin
    if (i_rst) state <= ST_IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n   = state;
    latch_en  = 1'b0;
    slot_clr  = 1'b0;
    o_loc_gnt = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (arb_any) begin
          latch_en = 1'b1;
          state_n  = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        o_loc_gnt = (acc_src == SRC_LOC);
        state_n   = ST_RESP;
      end
      ST_RESP: begin
        slot_clr = (acc_src == SRC_SPI);
        state_n  = ST_IDLE;
      end
      default: state_n = ST_IDLE;
    endcase
  end

  always_comb begin
    is_access  = (state == ST_ACCESS);
    acc_idx    = acc_addr[IDX_W-1:0];
    acc_mapped = ({1'b0, acc_addr} < DEPTH_C);
    rd_word    = acc_mapped ? bank[acc_idx] : ERR_WORD;
`ifdef SPI_REG_WPROT_EN
    // Lock blocks SPI writes to every register except itself.
    wr_block = (acc_src == SRC_SPI) &&
               (acc_idx != IDX_W'(REG_DEPTH - 1)) &&
               bank[REG_DEPTH-1][LOCK_BIT];
`else
    wr_block = 1'b0;
`endif
    do_write = is_access & acc_we & acc_mapped & ~wr_block;
    acc_err  = is_access &
               (~acc_mapped | (acc_we & wr_block));
    // A slot being emptied this cycle can take a new strobe.
    cmd_valid = i_reg_operate & (i_spi_write | i_spi_read);
    drop      = cmd_valid & slot_full & ~slot_clr;
    load      = cmd_valid & ~drop;
    err_sum   = {1'b0, o_err_cnt} + {8'b0, drop} +
                {8'b0, acc_err};
    err_next  = err_sum[8] ? 8'hFF : err_sum[7:0];
  end

  always_ff @(posedge i_master_clock) begin
    if (i_rst) begin
      for (int i = 0; i < REG_DEPTH; i++) bank[i] <= '0;
    end else if (do_write) begin
      bank[acc_idx] <= acc_data;
    end
  end

  always_ff @(posedge i_master_clock) begin
    if (i_rst) begin
      slot_full        <= 1'b0;
      slot_rd          <= 1'b0;
      slot_addr        <= '0;
      slot_data        <= '0;
      acc_src          <= SRC_SPI;
      acc_we           <= 1'b0;
      acc_addr         <= '0;
      acc_data         <= '0;
      o_data_word_send <= '0;
      o_loc_rdata      <= '0;
      o_loc_rvalid     <= 1'b0;
      o_err_cnt        <= '0;
    end else begin
      o_err_cnt <= err_next;
      if (load) begin
        slot_full <= 1'b1;
        slot_rd   <= i_spi_read;
        slot_addr <= i_spi_addr;
        slot_data <= i_spi_data;
      end else if (slot_clr) begin
        slot_full <= 1'b0;
      end
      if (latch_en) begin
        if (arb_win_loc) begin
          acc_src  <= SRC_LOC;
          acc_we   <= i_loc_we;
          acc_addr <= i_loc_addr;
          acc_data <= i_loc_wdata;
        end else begin
          acc_src  <= SRC_SPI;
          acc_we   <= ~slot_rd;
          acc_addr <= slot_addr;
          acc_data <= slot_data;
        end
      end
      o_loc_rvalid <= 1'b0;
      if (is_access && !acc_we) begin
        if (acc_src == SRC_SPI) begin
          o_data_word_send <= rd_word;
        end else begin
          o_loc_rdata  <= rd_word;
          o_loc_rvalid <= 1'b1;
        end
      end
    end
  end

  assign o_reg0 = bank[0];

endmodule
